fetch_ctrl: RTL and testbench

- Fetch-stage control: owns the PC register and the IF/ID pipeline register.
- Acts on the stall_decode and flush_fetch outputs of the hazard detector.
  - A stall freezes PC and IF/ID.
  - A flush redirects PC to the resolved target and injects a NOP bubble.
  - A fetched HALT freezes the PC until a flush squashes it.
- Sits between instruction memory and decode.
- Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/fetch_ctrl_pkg.sv | 24 ++
 rtl/fetch_ctrl_pipe_if_id.sv | 40 ++++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch stage: opcodes, the bubble word, PC source
// select and the fetch state.
package fetch_ctrl_pkg;

    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam logic [4:0]  OP_NOP    = 5'b00001;
    localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'b000_0000_0000};

    typedef enum logic [1:0] {
        PC_HOLD     = 2'b00,
        PC_INC      = 2'b01,
        PC_REDIRECT = 2'b10
    } pc_source_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [4:0] opcode);
        return (opcode == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_ctrl_pipe_if_id.sv
// IF/ID pipeline register: loads when enabled, squash forces a bubble and
// takes priority over the enable.
module pipe_if_id #(
    parameter int          PC_W      = 16,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            squash,
    input  logic [15:0]     instr,
    input  logic [PC_W-1:0] inc_pc,
    input  logic            valid,
    output logic [15:0]     instr_r,
    output logic [PC_W-1:0] inc_pc_r,
    output logic            valid_r
);

    // IF/ID storage with squash-to-bubble and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r  <= NOP_INSTR;
            inc_pc_r <= {PC_W{1'b0}};
            valid_r  <= 1'b0;
        end else if (squash) begin
            instr_r  <= NOP_INSTR;
            inc_pc_r <= {PC_W{1'b0}};
            valid_r  <= 1'b0;
        end else if (en) begin
            instr_r  <= instr;
            inc_pc_r <= inc_pc;
            valid_r  <= valid;
        end else begin
            instr_r  <= instr_r;
            inc_pc_r <= inc_pc_r;
            valid_r  <= valid_r;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage control: PC register, HALT state, next-PC select, IF/ID register
// and a saturating stall-cycle counter.
module fetch_ctrl #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [15:0]     NOP_INSTR = fetch_ctrl_pkg::NOP_INSTR,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_decode,
    input  logic             flush_fetch,
    input  logic [PC_W-1:0]  branch_target,
    input  logic [15:0]      imem_instr,
    output logic [PC_W-1:0]  imem_addr,
    output logic [15:0]      instr_IF_ID,
    output logic [PC_W-1:0]  inc_pc_IF_ID,
    output logic             valid_IF_ID,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    import fetch_ctrl_pkg::*;

    localparam logic [PC_W-1:0]  PC_STEP = {{(PC_W-2){1'b0}}, 2'b10};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PC_W-1:0]  pc_r;
    logic [PC_W-1:0]  pc_inc_s;
    logic [PC_W-1:0]  pc_next_s;
    fetch_state_t     state_r;
    fetch_state_t     next_state_s;
    pc_source_t       pc_src_s;
    logic             if_en_s;
    logic             if_squash_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign pc_inc_s    = pc_r + PC_STEP;
    assign imem_addr   = pc_r;
    assign halted      = (state_r == HALTED);
    assign stall_count = stall_cnt_r;

    // Priority decode: flush over stall over advance; HALT freezes the PC
    always_comb begin
        pc_src_s     = PC_HOLD;
        next_state_s = state_r;
        if_en_s      = 1'b0;
        if_squash_s  = 1'b0;
        if (flush_fetch) begin
            pc_src_s     = PC_REDIRECT;
            next_state_s = RUN;
            if_squash_s  = 1'b1;
        end else if (stall_decode) begin
            pc_src_s = PC_HOLD;
        end else begin
            case (state_r)
                RUN: begin
                    if_en_s = 1'b1;
                    if (is_halt(imem_instr[15:11])) begin
                        pc_src_s     = PC_HOLD;
                        next_state_s = HALTED;
                    end else begin
                        pc_src_s = PC_INC;
                    end
                end
                HALTED: begin
                    if_squash_s = 1'b1;
                end
                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // Next-PC mux
    always_comb begin
        pc_next_s = pc_r;
        case (pc_src_s)
            PC_HOLD:     pc_next_s = pc_r;
            PC_INC:      pc_next_s = pc_inc_s;
            PC_REDIRECT: pc_next_s = branch_target;
            default:     pc_next_s = pc_r;
        endcase
    end

    // PC and fetch state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            state_r <= RUN;
        end else begin
            pc_r    <= pc_next_s;
            state_r <= next_state_s;
        end
    end

    // Stall-cycle counter; a flush cycle never counts as a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!flush_fetch && stall_decode && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    pipe_if_id #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .en       (if_en_s),
        .squash   (if_squash_s),
        .instr    (imem_instr),
        .inc_pc   (pc_inc_s),
        .valid    (1'b1),
        .instr_r  (instr_IF_ID),
        .inc_pc_r (inc_pc_IF_ID),
        .valid_r  (valid_IF_ID)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed vectors push expected IF-stage
// state; a monitor pops and compares after each clock edge or reset assertion.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_decode = 1'b0;
    logic        flush_fetch = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_instr = 16'h0000;

    logic [15:0] imem_addr, instr_IF_ID, inc_pc_IF_ID;
    logic        valid_IF_ID, halted;
    logic [15:0] stall_count;

    logic [15:0] s_imem_addr, s_instr, s_inc_pc;
    logic        s_valid, s_halted;
    logic [3:0]  s_stall_count;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] inc;
        logic        valid;
        logic        halted;
        logic        chk_inc;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_decode  (stall_decode),
        .flush_fetch   (flush_fetch),
        .branch_target (branch_target),
        .imem_instr    (imem_instr),
        .imem_addr     (imem_addr),
        .instr_IF_ID   (instr_IF_ID),
        .inc_pc_IF_ID  (inc_pc_IF_ID),
        .valid_IF_ID   (valid_IF_ID),
        .halted        (halted),
        .stall_count   (stall_count)
    );

    fetch_ctrl #(.CNT_W(4)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .stall_decode  (stall_decode),
        .flush_fetch   (flush_fetch),
        .branch_target (branch_target),
        .imem_instr    (imem_instr),
        .imem_addr     (s_imem_addr),
        .instr_IF_ID   (s_instr),
        .inc_pc_IF_ID  (s_inc_pc),
        .valid_IF_ID   (s_valid),
        .halted        (s_halted),
        .stall_count   (s_stall_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] i, input logic [15:0] c,
                                input logic v, input logic h, input int n);
        exp_t e;
        e.addr    = a;
        e.instr   = i;
        e.inc     = c;
        e.valid   = v;
        e.halted  = h;
        e.chk_inc = 1'b1;
        e.cnt     = 16'(n);
        e.cnt4    = (n > 15) ? 4'hF : 4'(n);
        return e;
    endfunction

    function automatic exp_t mk_noinc(input logic [15:0] a, input logic [15:0] i,
                                      input logic v, input logic h, input int n);
        exp_t e;
        e = mk(a, i, 16'h0000, v, h, n);
        e.chk_inc = 1'b0;
        return e;
    endfunction

    // Drive one cycle of inputs, record what should follow the next edge
    task automatic step(input logic st, input logic fl, input logic [15:0] tgt,
                        input logic [15:0] im, input exp_t e);
        stall_decode  = st;
        flush_fetch   = fl;
        branch_target = tgt;
        imem_instr    = im;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare after every edge or reset assertion with an expectation pending
    always @(posedge clk or posedge rst) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("imem_addr", {16'h0000, imem_addr}, {16'h0000, mon_e.addr});
            check("instr_IF_ID", {16'h0000, instr_IF_ID}, {16'h0000, mon_e.instr});
            if (mon_e.chk_inc) check("inc_pc_IF_ID", {16'h0000, inc_pc_IF_ID}, {16'h0000, mon_e.inc});
            check("valid_IF_ID", {31'h0, valid_IF_ID}, {31'h0, mon_e.valid});
            check("halted", {31'h0, halted}, {31'h0, mon_e.halted});
            check("stall_count", {16'h0000, stall_count}, {16'h0000, mon_e.cnt});
            check("stall_count_w4", {28'h0, s_stall_count}, {28'h0, mon_e.cnt4});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        q.push_back(mk(16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 0));
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // sequential fetch
        step(1'b0, 1'b0, 16'h0000, 16'h4000, mk(16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0, 0));
        step(1'b0, 1'b0, 16'h0000, 16'h4100, mk(16'h0004, 16'h4100, 16'h0004, 1'b1, 1'b0, 0));
        // stall three cycles at PC=4, then a stall with HALT on the bus
        for (int i = 1; i <= 3; i++)
            step(1'b1, 1'b0, 16'h0000, 16'h4200, mk(16'h0004, 16'h4100, 16'h0004, 1'b1, 1'b0, i));
        step(1'b1, 1'b0, 16'h0000, 16'h0000, mk(16'h0004, 16'h4100, 16'h0004, 1'b1, 1'b0, 4));
        step(1'b0, 1'b0, 16'h0000, 16'h4200, mk(16'h0006, 16'h4200, 16'h0006, 1'b1, 1'b0, 4));
        step(1'b0, 1'b0, 16'h0000, 16'h4300, mk(16'h0008, 16'h4300, 16'h0008, 1'b1, 1'b0, 4));
        // flush, then flush together with stall
        step(1'b0, 1'b1, 16'h0040, 16'h4400, mk(16'h0040, 16'h0800, 16'h0000, 1'b0, 1'b0, 4));
        step(1'b0, 1'b0, 16'h0000, 16'h4500, mk(16'h0042, 16'h4500, 16'h0042, 1'b1, 1'b0, 4));
        step(1'b1, 1'b1, 16'h0008, 16'h4600, mk(16'h0008, 16'h0800, 16'h0000, 1'b0, 1'b0, 4));
        // HALT capture, frozen fetch, stall while halted, flush out
        step(1'b0, 1'b0, 16'h0000, 16'h0000, mk(16'h0008, 16'h0000, 16'h000A, 1'b1, 1'b1, 4));
        step(1'b0, 1'b0, 16'h0000, 16'h4600, mk_noinc(16'h0008, 16'h0800, 1'b0, 1'b1, 4));
        step(1'b0, 1'b0, 16'h0000, 16'h4600, mk_noinc(16'h0008, 16'h0800, 1'b0, 1'b1, 4));
        step(1'b1, 1'b0, 16'h0000, 16'h4600, mk_noinc(16'h0008, 16'h0800, 1'b0, 1'b1, 5));
        step(1'b0, 1'b1, 16'h0010, 16'h4600, mk(16'h0010, 16'h0800, 16'h0000, 1'b0, 1'b0, 5));
        step(1'b0, 1'b0, 16'h0000, 16'h4700, mk(16'h0012, 16'h4700, 16'h0012, 1'b1, 1'b0, 5));
        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 16'hFFFE, 16'h4700, mk(16'hFFFE, 16'h0800, 16'h0000, 1'b0, 1'b0, 5));
        step(1'b0, 1'b0, 16'h0000, 16'h4800, mk(16'h0000, 16'h4800, 16'h0000, 1'b1, 1'b0, 5));
        // 20 stalls: the 4-bit counter saturates at 4'hF
        for (int i = 1; i <= 20; i++)
            step(1'b1, 1'b0, 16'h0000, 16'h4900, mk(16'h0000, 16'h4800, 16'h0000, 1'b1, 1'b0, 5 + i));
        // enter HALTED, then reset between edges while stalling
        step(1'b0, 1'b1, 16'h0020, 16'h4900, mk(16'h0020, 16'h0800, 16'h0000, 1'b0, 1'b0, 25));
        step(1'b0, 1'b0, 16'h0000, 16'h0000, mk(16'h0020, 16'h0000, 16'h0022, 1'b1, 1'b1, 25));
        stall_decode = 1'b1;
        imem_instr   = 16'h4900;
        #2;
        q.push_back(mk(16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 16'h4900, mk(16'h0002, 16'h4900, 16'h0002, 1'b1, 1'b0, 0));

        repeat (2) @(negedge clk);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
